mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Bus master between the multicycle control FSM and the unified memory.
//  Runs one load or store per start pulse over a req/ack bus, tolerating
//  any number of wait states. Produces byte-lane enables and replicated store
//  data. Aligns and sign/zero-extends load data into the 32-bit word that
//  feeds the memory data register.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max ACCESS cycles without bus_ack before abort (>=2)
//  CNT_W           5   timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset (0 = reset)
//  start       in   1   one-cycle request from control FSM; sampled in IDLE only
//  mem_read    in   1   load request qualifier
//  mem_write   in   1   store request qualifier (wins if both high)
//  size        in   2   00 byte, 01 half, 10 word, 11 treated as word
//  ld_unsigned in   1   1 = zero-extend sub-word loads, 0 = sign-extend
//  addr        in   32  byte address
//  wdata       in   32  store data, low-aligned
//  mem_rdata   out  32  aligned/extended load result (to MDR input)
//  done        out  1   one-cycle pulse: access complete (ok or error)
//  busy        out  1   high whenever state != IDLE
//  err         out  1   sticky error of last access; cleared on next accepted start
//  bus_req     out  1   bus request, held until ack
//  bus_we      out  1   1 = write cycle
//  bus_addr    out  32  word address {addr[31:2],2'b00}
//  bus_be      out  4   byte-lane enables, little-endian
//  bus_wdata   out  32  store data replicated across lanes
//  bus_rdata   in   32  raw read word, valid with bus_ack
//  bus_ack     in   1   one-cycle completion strobe from memory
// BEHAVIOUR
//  - Reset (async): state IDLE; bus_req, bus_we, done, busy, err = 0;
//    bus_be = 4'b0; bus_addr, bus_wdata, mem_rdata = 0; timeout counter = 0.
//    Reset mid-access drops bus_req immediately. No done is issued.
//  - States: IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: start & (mem_read|mem_write) at edge T: latch addr/size/ld_unsigned/
//    wdata/we; clear err; go to ACCESS. bus_req=1 from T+1.
//    start with neither qualifier: ignored.
//  - ACCESS: bus outputs are stable while bus_req=1. On bus_ack: deassert bus_req.
//    On a read, capture the extracted result into mem_rdata. Then go to DONE.
//  - Timeout: counter increments each ACCESS cycle without ack. If
//    count == TIMEOUT_CYCLES-1 and no ack, abort to DONE with err=1 and
//    mem_rdata=0. If ack arrives in that same cycle, ack wins.
//  - DONE: done=1 for exactly one cycle, busy still 1; next state is IDLE.
//  - Minimum latency: start@T, ack sampled @T+1, done high during T+2.
//  - start outside IDLE is ignored (no queueing).
//  - bus_ack while not in ACCESS is ignored.
//  - Byte enables: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
//  - bus_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
//  - Load extract: byte = bus_rdata[8*addr[1:0]+:8]; half = addr[1] ? [31:16] : [15:0].
//    Extend to 32 bits per ld_unsigned.
//  - mem_rdata holds its value until the next completed read, abort or reset.
//    Stores do not change it.
// CONFIGURATION
//  MEM_ACCESS_MISALIGN_CHECK_EN defined: on start in IDLE, a misaligned access
//    (half with addr[0]=1, or word with addr[1:0]!=0) issues no bus cycle.
//    It goes IDLE -> DONE with err=1 and mem_rdata unchanged; done at T+1.
//  Not defined: no check. Half uses addr[1] only; word ignores addr[1:0];
//    err is set only by timeout.
// TESTING
//  1 Word load, ack next cycle: addr=0x100, bus_rdata=0xDEADBEEF
//    -> bus_be=1111, done@T+2, mem_rdata=0xDEADBEEF, err=0.
//  2 Signed byte load addr=0x103, rdata=0x80112233 -> be=1000, mem_rdata=0xFFFFFF80;
//    same with ld_unsigned=1 -> 0x00000080.
//  3 Half store addr=0x202, wdata=0x0000ABCD, 3 wait states
//    -> bus_be=1100, bus_wdata=0xABCDABCD, bus_req held 4 cycles, done once.
//  4 No ack ever -> done exactly TIMEOUT_CYCLES+1 cycles after start, err=1,
//    mem_rdata=0; next good access clears err.
//  5 Reset low during ACCESS -> bus_req=0 at once, no done, busy=0.
//    start pulses while busy are ignored.
//  6 Word load addr=0x101 -> with MEM_ACCESS_MISALIGN_CHECK_EN: no bus_req, done@T+1,
//    err=1. Without it: bus_addr=0x100, normal completion.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one load/store per start over a req/ack bus, with lane steering and load extension.
// Optional MEM_ACCESS_MISALIGN_CHECK_EN rejects misaligned half/word accesses without a bus cycle.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_rdata,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    // state  | meaning
    // IDLE   | waiting for a qualified start
    // ACCESS | bus_req held, waiting for ack or timeout
    // DONE   | one-cycle completion pulse, busy still high
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_q;
    logic [1:0]       lane_q;
    logic             uns_q;
    logic             misaligned;

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   lane_be = 4'b0001 << a;
            2'b01:   lane_be = a[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] raw, input logic [1:0] sz,
                                            input logic [1:0] a, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[{a, 3'b000} +: 8];
        h = a[1] ? raw[31:16] : raw[15:0];
        case (sz)
            2'b00:   extract = {{24{b[7] & ~uns}}, b};
            2'b01:   extract = {{16{h[15] & ~uns}}, h};
            default: extract = raw;
        endcase
    endfunction

    always_comb begin
        misaligned = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            default: misaligned = |addr[1:0];
        endcase
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            size_q    <= 2'b00;
            lane_q    <= 2'b00;
            uns_q     <= 1'b0;
            mem_rdata <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (mem_read || mem_write)) begin
                        size_q <= size;
                        lane_q <= addr[1:0];
                        uns_q  <= ld_unsigned;
                        cnt    <= '0;
                        err    <= misaligned;
                        busy   <= 1'b1;
                        if (misaligned) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= lane_be(size, addr[1:0]);
                            bus_wdata <= lane_wdata(size, wdata);
                        end
                    end
                end
                ACCESS: begin
                    // ack in the final timeout cycle still completes normally
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= DONE;
                        done    <= 1'b1;
                        if (!bus_we)
                            mem_rdata <= extract(bus_rdata, size_q, lane_q, uns_q);
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus_req   <= 1'b0;
                        state     <= DONE;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        mem_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
